muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports SHALL be clk (in, 1) and rst_n (in, 1), listed first.
REQ-002 SHALL have op_valid  in  1  MULTU/DIVU issue request from the EX stage.
REQ-003 SHALL have op_div  in  1  0 = MULTU, 1 = DIVU.
REQ-004 SHALL have rs_data  in  32  multiplicand or dividend.
REQ-005 SHALL have rt_data  in  32  multiplier or divisor.
REQ-006 SHALL have mfhi_req and mflo_req  in  1 each  MFHI/MFLO decode signals from the control unit.
REQ-007 SHALL have hi and lo  out  32 each  architectural HI/LO registers.
REQ-008 SHALL have busy  out  1  high whenever state is not IDLE.
REQ-009 SHALL have stall  out  1  pipeline freeze request.
REQ-010 SHALL have op_err  out  1  one-cycle pulse when an unsupported operation is issued.

Function
REQ-011 SHALL use the states IDLE, RUN and DONE.
REQ-012 In IDLE, an op_valid request SHALL be accepted at the next clk edge (E0): operands are latched, iter counter cleared, next state RUN.
REQ-013 RUN SHALL last exactly 32 cycles, with the 5-bit iter counter counting 0..31 and performing one iteration per cycle; at count 31 the counter SHALL wrap to 0 and the next state SHALL be DONE.
REQ-014 DONE SHALL last 1 cycle, load hi/lo at its closing edge (E33) and return to IDLE; results SHALL be visible 33 edges after acceptance.
REQ-015 Multiply SHALL be unsigned shift-add with a 64-bit product: hi = product[63:32], lo = product[31:0].
REQ-016 Divide SHALL be unsigned restoring division: lo = quotient, hi = remainder.
REQ-017 DIVU with rt_data == 0 SHALL skip RUN (IDLE -> DONE at E0, then DONE -> IDLE at E1), producing hi = rs_data and lo = 32'hFFFFFFFF.
REQ-018 stall SHALL equal (op_valid | mfhi_req | mflo_req) & (state != IDLE), combinationally.
REQ-019 op_valid while not IDLE SHALL NOT be accepted; the requester holds it under stall, and it is accepted at the first edge in IDLE.
REQ-020 In IDLE, mfhi_req/mflo_req SHALL cause no stall; hi/lo are read directly.
REQ-021 op_valid together with mfhi_req/mflo_req in IDLE SHALL accept the op, with the read returning the pre-op hi/lo.
REQ-022 hi/lo SHALL change only at the DONE closing edge or at reset.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, iter counter 0, hi = 0, lo = 0, internal operand/accumulator registers 0, and busy, stall and op_err to 0.
REQ-024 Reset during RUN or DONE SHALL discard the in-flight operation with no partial HI/LO update.

Configuration
REQ-025 Macro MULDIV_SEQUENCER_DIV_EN SHALL control divide support.
REQ-026 With MULDIV_SEQUENCER_DIV_EN defined, REQ-016 and REQ-017 SHALL apply.
REQ-027 Without MULDIV_SEQUENCER_DIV_EN, the divide datapath SHALL be omitted; an op_valid with op_div = 1 in IDLE SHALL pulse op_err for 1 cycle, stay in IDLE and leave hi/lo unchanged. op_err SHALL be constant 0 when the macro is defined.

Structure
REQ-028 Package muldiv_pkg SHALL hold the state encoding, the op encoding (OP_MULTU = 0, OP_DIVU = 1), ITER_COUNT = 32 and DIV0_LO = 32'hFFFFFFFF.
REQ-029 Sub-module muldiv_iter_core SHALL hold the per-iteration shift-add and restoring-subtract datapath (64-bit accumulator, one step per enable); the FSM, counter, stall logic and HI/LO registers SHALL stay in muldiv_sequencer.

Verification
REQ-030 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy for 33 cycles; then hi = 0xFFFFFFFE, lo = 0x00000001.
REQ-031 DIVU 100 / 7 -> after 33 cycles lo = 14 (0x0000000E), hi = 2.
REQ-032 DIVU 0x12345678 / 0 -> after 2 edges hi = 0x12345678, lo = 0xFFFFFFFF; no RUN cycles.
REQ-033 mflo_req asserted 5 cycles after a MULTU 3 x 5 is accepted -> stall high until state returns to IDLE; on the first IDLE cycle stall = 0 and lo = 15.
REQ-034 rst_n pulsed low at RUN iteration 10 -> hi = lo = 0, busy = 0 and stall = 0 immediately; a subsequent MULTU 2 x 2 yields lo = 4.
REQ-035 Build without MULDIV_SEQUENCER_DIV_EN and issue DIVU 9 / 3 -> op_err high for exactly 1 cycle, busy stays 0, hi/lo unchanged.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative MULTU/DIVU sequencer.
package muldiv_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_MULTU = 1'b0,
    OP_DIVU  = 1'b1
  } op_e;

  localparam int          ITER_COUNT = 32;
  localparam int          ITER_W     = $clog2(ITER_COUNT);
  localparam logic [31:0] DIV0_LO    = 32'hFFFFFFFF;
endpackage

// File: rtl/muldiv_iter_core.sv
// One-bit-per-cycle datapath: shift-add multiply and restoring divide
// sharing a 64-bit accumulator. Divide path exists only when
// MULDIV_SEQUENCER_DIV_EN is defined.
module muldiv_iter_core
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        step_i,
`ifdef MULDIV_SEQUENCER_DIV_EN
  input  logic        op_div_i,
`endif
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] acc_o
);
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q;
  logic [32:0] mul_sum, mul_hi;
  logic [63:0] mul_nxt;
`ifdef MULDIV_SEQUENCER_DIV_EN
  logic        div_q;
  logic [64:0] div_shl;
  logic [32:0] div_diff;
  logic [63:0] div_nxt;
`endif

  // Multiply: acc = {partial, multiplier}; add multiplicand when LSB set, then shift right with carry.
  assign mul_sum = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
  assign mul_hi  = acc_q[0] ? mul_sum : {1'b0, acc_q[63:32]};
  assign mul_nxt = {mul_hi, acc_q[31:1]};

`ifdef MULDIV_SEQUENCER_DIV_EN
  // Divide: acc = {remainder, dividend/quotient}; shift left, keep the subtraction if it did not borrow.
  assign div_shl  = {acc_q, 1'b0};
  assign div_diff = div_shl[64:32] - {1'b0, opnd_q};
  assign div_nxt  = div_diff[32] ? div_shl[63:0] : {div_diff[31:0], div_shl[31:1], 1'b1};
`endif

  // Next accumulator value: load operands, step the selected algorithm, or hold.
  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = {32'd0, b_i};
`ifdef MULDIV_SEQUENCER_DIV_EN
      if (op_div_i) acc_d = {32'd0, a_i};
`endif
    end else if (step_i) begin
      acc_d = mul_nxt;
`ifdef MULDIV_SEQUENCER_DIV_EN
      if (div_q) acc_d = div_nxt;
`endif
    end
  end

  // Accumulator and operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
`ifdef MULDIV_SEQUENCER_DIV_EN
      div_q  <= 1'b0;
`endif
    end else begin
      acc_q <= acc_d;
      if (load_i) begin
        opnd_q <= a_i;
`ifdef MULDIV_SEQUENCER_DIV_EN
        div_q  <= op_div_i;
        if (op_div_i) opnd_q <= b_i;
`endif
      end
    end
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/muldiv_sequencer.sv
// MULTU/DIVU sequencer: IDLE -> RUN (32 iterations) -> DONE, owns HI/LO
// and the pipeline stall. Divide support under MULDIV_SEQUENCER_DIV_EN.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic        op_div,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        mfhi_req,
  input  logic        mflo_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        op_err
);
  state_e            state_q;
  logic [ITER_W-1:0] iter_q;
  logic [31:0]       hi_q, lo_q;
  logic [63:0]       acc;
  logic              core_load;

`ifdef MULDIV_SEQUENCER_DIV_EN
  logic div0_q;
  logic div0;
  assign div0      = (op_div == OP_DIVU) && (rt_data == '0);
  assign core_load = (state_q == ST_IDLE) && op_valid;
  assign op_err    = 1'b0;
`else
  logic op_err_q;
  // Unsupported divides never reach the datapath.
  assign core_load = (state_q == ST_IDLE) && op_valid && (op_div == OP_MULTU);
  assign op_err    = op_err_q;
`endif

  muldiv_iter_core u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (core_load),
    .step_i   (state_q == ST_RUN),
`ifdef MULDIV_SEQUENCER_DIV_EN
    .op_div_i (op_div),
`endif
    .a_i      (rs_data),
    .b_i      (rt_data),
    .acc_o    (acc)
  );

  // Control FSM with iteration counter and HI/LO commit at the DONE edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      iter_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MULDIV_SEQUENCER_DIV_EN
      div0_q   <= 1'b0;
`else
      op_err_q <= 1'b0;
`endif
    end else begin
`ifndef MULDIV_SEQUENCER_DIV_EN
      op_err_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: if (op_valid) begin
`ifdef MULDIV_SEQUENCER_DIV_EN
          iter_q  <= '0;
          div0_q  <= div0;
          state_q <= div0 ? ST_DONE : ST_RUN;
`else
          if (op_div == OP_DIVU) begin
            op_err_q <= 1'b1;
          end else begin
            iter_q  <= '0;
            state_q <= ST_RUN;
          end
`endif
        end
        ST_RUN: begin
          iter_q <= iter_q + 1'b1;
          if (iter_q == ITER_W'(ITER_COUNT - 1)) state_q <= ST_DONE;
        end
        ST_DONE: begin
          hi_q    <= acc[63:32];
          lo_q    <= acc[31:0];
`ifdef MULDIV_SEQUENCER_DIV_EN
          // Divide by zero: the dividend is still sitting in the low half.
          if (div0_q) begin
            hi_q <= acc[31:0];
            lo_q <= DIV0_LO;
          end
          div0_q  <= 1'b0;
`endif
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign stall = (op_valid | mfhi_req | mflo_req) & busy;
  assign hi    = hi_q;
  assign lo    = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected {hi,lo} pushed at issue,
// popped when busy drops.
module tb_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid, op_div, mfhi_req, mflo_req;
  logic [31:0] rs_data, rt_data;
  logic [31:0] hi, lo;
  logic        busy, stall, op_err;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] sb_q[$];
  logic [63:0] last_res;

  muldiv_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op_div   (op_div),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .mfhi_req (mfhi_req),
    .mflo_req (mflo_req),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .stall    (stall),
    .op_err   (op_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic div, input logic [31:0] a, input logic [31:0] b);
    if (!div) return {32'd0, a} * {32'd0, b};
    if (b == 0) return {a, 32'hFFFFFFFF};
    return {a % b, a / b};
  endfunction

  // Present an op for one edge; returns at the negedge after acceptance.
  task automatic drive_op(input logic div, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_valid = 1'b1; op_div = div; rs_data = a; rt_data = b;
    sb_q.push_back(model(div, a, b));
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  // Count busy cycles (bounded), then compare HI/LO with the scoreboard head.
  task automatic wait_done(input int exp_cyc);
    int cyc = 0;
    logic [63:0] exp;
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    chk("busy_cycles", 64'(cyc), 64'(exp_cyc));
    if (sb_q.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      exp = sb_q.pop_front();
      chk("hi", {32'd0, hi}, {32'd0, exp[63:32]});
      chk("lo", {32'd0, lo}, {32'd0, exp[31:0]});
      last_res = exp;
    end
  endtask

  initial begin
    rst_n = 1'b0; op_valid = 1'b0; op_div = 1'b0; rs_data = '0; rt_data = '0;
    mfhi_req = 1'b0; mflo_req = 1'b0; last_res = '0;
    repeat (2) @(negedge clk);
    mflo_req = 1'b1;
    #1;
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_operr", 64'(op_err), 64'd0);
    mflo_req = 1'b0;
    rst_n = 1'b1;

    // Multiply patterns
    drive_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_done(33);
    drive_op(1'b0, 32'h0, 32'h1234);            wait_done(33);
    drive_op(1'b0, 32'h80000000, 32'h2);        wait_done(33);
    for (int i = 0; i < 3; i++) begin
      drive_op(1'b0, $urandom, $urandom); wait_done(33);
    end

`ifdef MULDIV_SEQUENCER_DIV_EN
    drive_op(1'b1, 32'd100, 32'd7);             wait_done(33);
    drive_op(1'b1, 32'h12345678, 32'd0);        wait_done(1);
    drive_op(1'b1, 32'hFFFFFFFF, 32'h1);        wait_done(33);
    for (int i = 0; i < 3; i++) begin
      drive_op(1'b1, $urandom, $urandom_range(32'hFFFF, 1)); wait_done(33);
    end
    chk("operr_div", 64'(op_err), 64'd0);
`else
    // Divide not built: one-cycle error pulse, no state change
    @(negedge clk);
    op_valid = 1'b1; op_div = 1'b1; rs_data = 32'd9; rt_data = 32'd3;
    @(negedge clk);
    op_valid = 1'b0;
    chk("operr_pulse", 64'(op_err), 64'd1);
    chk("operr_busy0", 64'(busy), 64'd0);
    @(negedge clk);
    chk("operr_clear", 64'(op_err), 64'd0);
    chk("operr_busy1", 64'(busy), 64'd0);
    chk("operr_hilo", {hi, lo}, last_res);
`endif

    // MFLO issued mid-operation stalls until IDLE
    drive_op(1'b0, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    chk("hilo_hold", {hi, lo}, last_res);
    mflo_req = 1'b1;
    #1;
    chk("mflo_stall", 64'(stall), 64'd1);
    wait_done(29);
    chk("mflo_idle_stall", 64'(stall), 64'd0);
    chk("mflo_lo15", {32'd0, lo}, 64'd15);
    mflo_req = 1'b0;

    // Op held under stall is taken at the first IDLE edge
    drive_op(1'b0, 32'd7, 32'd6);
    op_valid = 1'b1; op_div = 1'b0; rs_data = 32'h10001; rt_data = 32'h10001;
    sb_q.push_back(model(1'b0, 32'h10001, 32'h10001));
    mfhi_req = 1'b1;
    #1;
    chk("held_stall", 64'(stall), 64'd1);
    wait_done(33);
    chk("held_idle_stall", 64'(stall), 64'd0);
    @(negedge clk);
    op_valid = 1'b0; mfhi_req = 1'b0;
    chk("held_accept", 64'(busy), 64'd1);
    chk("held_prev_lo", {32'd0, lo}, 64'd42);
    wait_done(33);

    // Reset mid-RUN discards the operation
    drive_op(1'b0, 32'hDEAD, 32'hBEEF);
    repeat (10) @(negedge clk);
    mflo_req = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_hi", {32'd0, hi}, 64'd0);
    chk("mrst_lo", {32'd0, lo}, 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_stall", 64'(stall), 64'd0);
    void'(sb_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1; mflo_req = 1'b0;
    drive_op(1'b0, 32'd2, 32'd2); wait_done(33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
